// File: rtl/io_debug_bridge_pkg.sv
// Shared constants, command-byte layout and FSM state type for io_debug_bridge.
package io_debug_bridge_pkg;

    localparam logic [7:0] BRIDGE_ACK   = 8'hA5;
    localparam logic [7:0] BRIDGE_ERR   = 8'hEE;

    localparam int         CMD_WR_BIT   = 7;
    localparam int         CMD_RSV_BIT  = 6;
    localparam int         CMD_ADDR_MSB = 5;
    localparam int         ADDR_W       = CMD_ADDR_MSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        GETDATA,
        REQ,
        STROBE,
        WAIT_RD,
        SEND
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/io_debug_bridge_if.sv
// Byte streams, bus arbitration and I/O port of the debug bridge.
// master = bridge side, slave = UART / core / peripheral side.
interface io_debug_bridge_if;
    import io_debug_bridge_pkg::*;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              bus_req;
    logic              bus_gnt;
    logic              io_re;
    logic              io_we;
    logic [ADDR_W-1:0] io_a;
    logic [7:0]        io_do;
    logic [7:0]        io_di;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_gnt, io_di,
        output rx_ready, tx_data, tx_valid, bus_req, io_re, io_we, io_a, io_do
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_gnt, io_di,
        input  rx_ready, tx_data, tx_valid, bus_req, io_re, io_we, io_a, io_do
    );

endinterface

// File: rtl/io_debug_bridge.sv
// Byte-command debug bridge: UART-style commands drive single I/O-port reads/writes.
// Define IO_BRIDGE_WRACK_EN to answer each completed write with BRIDGE_ACK.
module io_debug_bridge
    import io_debug_bridge_pkg::*;
#(
    parameter int RD_LAT      = 1,
    parameter int GNT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    io_debug_bridge_if.master bif,
    output logic              busy
);

    localparam logic [1:0] RD_LAT_C  = 2'(RD_LAT);
    localparam logic [7:0] TIMEOUT_C = 8'(GNT_TIMEOUT);

    state_t            state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] io_a_q, io_a_d;
    logic [7:0]        io_do_q, io_do_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              rx_ready_q, rx_ready_d;
    logic              tx_valid_q, tx_valid_d;
    logic              bus_req_q, bus_req_d;
    logic              io_re_q, io_re_d;
    logic              io_we_q, io_we_d;
    logic              busy_q, busy_d;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves a latch behind.
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        io_a_d    = io_a_q;
        io_do_d   = io_do_q;
        tx_data_d = tx_data_q;

        unique case (state_q)
            IDLE: begin
                if (bif.rx_valid && rx_ready_q) begin
                    io_a_d  = bif.rx_data[CMD_ADDR_MSB:0];
                    is_wr_d = bif.rx_data[CMD_WR_BIT];
                    cnt_d   = '0;
                    if (bif.rx_data[CMD_RSV_BIT]) begin
                        tx_data_d = BRIDGE_ERR;
                        state_d   = SEND;
                    end else if (bif.rx_data[CMD_WR_BIT]) begin
                        state_d = GETDATA;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            GETDATA: begin
                if (bif.rx_valid && rx_ready_q) begin
                    io_do_d = bif.rx_data;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Grant wins over a timeout landing on the same edge.
                if (bif.bus_gnt) begin
                    state_d = STROBE;
                end else begin
                    cnt_d = sat_inc8(cnt_q);
                    if (sat_inc8(cnt_q) >= TIMEOUT_C) begin
                        tx_data_d = BRIDGE_ERR;
                        state_d   = SEND;
                    end
                end
            end
            STROBE: begin
                if (is_wr_q) begin
`ifdef IO_BRIDGE_WRACK_EN
                    tx_data_d = BRIDGE_ACK;
                    state_d   = SEND;
`else
                    state_d   = IDLE;
`endif
                end else begin
                    lat_d   = 2'd1;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // A dropped grant here is ignored: the strobe already happened.
                if (lat_q == RD_LAT_C) begin
                    tx_data_d = bif.io_di;
                    state_d   = SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            SEND: begin
                if (bif.tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered decodes of the next state.
        rx_ready_d = (state_d == IDLE) || (state_d == GETDATA);
        tx_valid_d = (state_d == SEND);
        bus_req_d  = (state_d == REQ) || (state_d == STROBE) || (state_d == WAIT_RD);
        io_re_d    = (state_d == STROBE) && !is_wr_d;
        io_we_d    = (state_d == STROBE) && is_wr_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; rst_n is only looked at on the clock edge.
        if (!rst_n) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            cnt_q      <= '0;
            lat_q      <= '0;
            io_a_q     <= '0;
            io_do_q    <= '0;
            tx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            bus_req_q  <= 1'b0;
            io_re_q    <= 1'b0;
            io_we_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            io_a_q     <= io_a_d;
            io_do_q    <= io_do_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            bus_req_q  <= bus_req_d;
            io_re_q    <= io_re_d;
            io_we_q    <= io_we_d;
            busy_q     <= busy_d;
        end
    end

    assign bif.rx_ready = rx_ready_q;
    assign bif.tx_data  = tx_data_q;
    assign bif.tx_valid = tx_valid_q;
    assign bif.bus_req  = bus_req_q;
    assign bif.io_re    = io_re_q;
    assign bif.io_we    = io_we_q;
    assign bif.io_a     = io_a_q;
    assign bif.io_do    = io_do_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_io_debug_bridge.sv
// Directed self-checking bench for io_debug_bridge (RD_LAT = 1, GNT_TIMEOUT = 4).
// Expectations follow IO_BRIDGE_WRACK_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_io_debug_bridge;
    import io_debug_bridge_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    io_debug_bridge_if bif();

    io_debug_bridge #(.RD_LAT(1), .GNT_TIMEOUT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bif  (bif.master),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bus monitor, sampled on the falling edge.
    int         re_cnt = 0, we_cnt = 0, tx_cnt = 0, req_cyc = 0;
    int         overlap_err = 0, nognt_err = 0;
    logic [7:0] last_tx = 8'h00;
    logic [5:0] strobe_a = 6'h00;
    logic [7:0] strobe_do = 8'h00;
    logic       gnt_seen = 1'b0;

    always @(negedge clk) begin
        if (bif.io_re) re_cnt++;
        if (bif.io_we) we_cnt++;
        if (bif.io_re && bif.io_we) overlap_err++;
        if ((bif.io_re || bif.io_we) && !gnt_seen) nognt_err++;
        if (bif.io_re || bif.io_we) begin
            strobe_a  = bif.io_a;
            strobe_do = bif.io_do;
        end
        if (bif.tx_valid && bif.tx_ready) begin
            tx_cnt++;
            last_tx = bif.tx_data;
        end
        if (bif.bus_req) req_cyc++;
        gnt_seen = bif.bus_req && (gnt_seen || bif.bus_gnt);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        bit done = 1'b0;
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = bif.rx_ready;
            tick();
        end
        bif.rx_valid = 1'b0;
        check($sformatf("rx_accept_%02h", b), done, 1);
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bif.io_re || bif.io_we) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_tx_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bif.tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    int b_re, b_we, b_tx, b_req;
    bit ok;
    int unstable;

    task automatic snap();
        b_re  = re_cnt;
        b_we  = we_cnt;
        b_tx  = tx_cnt;
        b_req = req_cyc;
    endtask

    initial begin
        bif.rx_data  = 8'h00;
        bif.rx_valid = 1'b0;
        bif.tx_ready = 1'b0;
        bif.bus_gnt  = 1'b0;
        bif.io_di    = 8'h99;

        // Reset values
        tick(3);
        check("rst_busy",     busy,         0);
        check("rst_bus_req",  bif.bus_req,  0);
        check("rst_io_re",    bif.io_re,    0);
        check("rst_io_we",    bif.io_we,    0);
        check("rst_tx_valid", bif.tx_valid, 0);
        check("rst_io_a",     bif.io_a,     0);
        check("rst_io_do",    bif.io_do,    0);
        check("rst_tx_data",  bif.tx_data,  0);
        rst_n = 1'b1;
        tick();
        check("idle_rx_ready", bif.rx_ready, 1);

        // Read: grant after 3 cycles, io_di valid only in the sample cycle
        bif.tx_ready = 1'b1;
        snap();
        send_rx(8'h05);
        check("rd_busy",     busy,         1);
        check("rd_rx_ready", bif.rx_ready, 0);
        tick(3);
        check("rd_req_pre_gnt", bif.bus_req, 1);
        bif.bus_gnt = 1'b1;
        wait_strobe(ok);
        check("rd_strobe_seen", ok,        1);
        check("rd_io_re",       bif.io_re, 1);
        check("rd_io_we",       bif.io_we, 0);
        check("rd_io_a",        bif.io_a,  6'h05);
        tick();
        bif.bus_gnt = 1'b0;
        bif.io_di   = 8'h3C;
        check("rd_wait_req",  bif.bus_req, 1);
        check("rd_re_single", bif.io_re,   0);
        tick();
        bif.io_di = 8'h99;
        check("rd_req_drop", bif.bus_req,  0);
        check("rd_tx_valid", bif.tx_valid, 1);
        check("rd_tx_data",  bif.tx_data,  8'h3C);
        tick(2);
        check("rd_re_pulses", re_cnt - b_re, 1);
        check("rd_we_pulses", we_cnt - b_we, 0);
        check("rd_tx_count",  tx_cnt - b_tx, 1);
        check("rd_last_tx",   last_tx,       8'h3C);
        check("rd_idle",      busy,          0);

        // Write: 0x87 then 0x55 with grant held high
        snap();
        bif.bus_gnt = 1'b1;
        send_rx(8'h87);
        send_rx(8'h55);
        wait_strobe(ok);
        check("wr_strobe_seen", ok,        1);
        check("wr_io_we",       bif.io_we, 1);
        check("wr_io_re",       bif.io_re, 0);
        check("wr_io_a",        bif.io_a,  6'h07);
        check("wr_io_do",       bif.io_do, 8'h55);
        tick();
        check("wr_req_drop", bif.bus_req, 0);
        bif.bus_gnt = 1'b0;
        tick(4);
        check("wr_we_pulses", we_cnt - b_we, 1);
        check("wr_strobe_a",  strobe_a,      6'h07);
        check("wr_strobe_do", strobe_do,     8'h55);
`ifdef IO_BRIDGE_WRACK_EN
        check("wr_tx_count", tx_cnt - b_tx, 1);
        check("wr_last_tx",  last_tx,       8'hA5);
`else
        check("wr_tx_count", tx_cnt - b_tx, 0);
`endif
        check("wr_idle", busy, 0);

        // Grant timeout
        snap();
        send_rx(8'h01);
        wait_tx_valid(ok);
        check("to_tx_seen",  ok,          1);
        check("to_tx_data",  bif.tx_data, 8'hEE);
        check("to_req_drop", bif.bus_req, 0);
        tick(2);
        check("to_req_cycles", req_cyc - b_req,                 4);
        check("to_no_strobe",  (re_cnt - b_re) + (we_cnt - b_we), 0);
        check("to_tx_count",   tx_cnt - b_tx,                   1);
        check("to_last_tx",    last_tx,                         8'hEE);

        // Reserved bit set
        snap();
        bif.bus_gnt = 1'b1;
        send_rx(8'h41);
        tick(4);
        bif.bus_gnt = 1'b0;
        check("rsv_tx_count", tx_cnt - b_tx,   1);
        check("rsv_last_tx",  last_tx,         8'hEE);
        check("rsv_no_req",   req_cyc - b_req, 0);

        // Backpressure: tx_ready low for 10 cycles
        snap();
        bif.tx_ready = 1'b0;
        send_rx(8'h41);
        wait_tx_valid(ok);
        check("bp_tx_seen", ok, 1);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bif.tx_valid || bif.tx_data !== 8'hEE) unstable++;
        end
        check("bp_stable",    unstable,      0);
        check("bp_no_xfer",   tx_cnt - b_tx, 0);
        check("bp_rx_ready",  bif.rx_ready,  0);
        bif.tx_ready = 1'b1;
        tick();
        check("bp_valid_drop", bif.tx_valid, 0);
        tick();
        check("bp_tx_count", tx_cnt - b_tx, 1);

        // Reset during WAIT_RD
        snap();
        bif.bus_gnt = 1'b1;
        bif.io_di   = 8'h3C;
        send_rx(8'h0A);
        wait_strobe(ok);
        check("rr_strobe_seen", ok, 1);
        tick();
        check("rr_in_wait", bif.bus_req, 1);
        rst_n = 1'b0;
        tick();
        check("rr_busy",     busy,         0);
        check("rr_bus_req",  bif.bus_req,  0);
        check("rr_io_re",    bif.io_re,    0);
        check("rr_tx_valid", bif.tx_valid, 0);
        check("rr_io_a",     bif.io_a,     0);
        check("rr_tx_data",  bif.tx_data,  0);
        rst_n       = 1'b1;
        bif.bus_gnt = 1'b0;
        bif.io_di   = 8'h99;
        tick(5);
        check("rr_no_tx",    tx_cnt - b_tx, 0);
        check("rr_re_once",  re_cnt - b_re, 1);
        check("rr_rx_ready", bif.rx_ready,  1);

        // Strobe safety over the whole run
        check("strobe_overlap",  overlap_err, 0);
        check("strobe_no_grant", nognt_err,   0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
